// File: rtl/vector_lane_sequencer.sv
`timescale 1ns/1ps
// Vector lane sequencer: splits a vector instruction into LANES-wide
// beats, issues them and tracks writeback through per-unit latency.
package rv32v_types_pkg;
  typedef enum logic [2:0] {
    ARITH, RED, MUL, DIV, MASK, PEM, LOAD_UNIT, STORE_UNIT
  } fu_t;
endpackage

module vector_lane_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int VLMAX   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     start,
  input  fu_t                      fu_type,
  input  logic [$clog2(VLMAX):0]   vl,
  input  logic                     stall,
  input  logic                     abort,
  input  logic                     done_du,
  output logic                     fu_valid,
  output logic [$clog2(VLMAX)-1:0] eidx,
  output logic [LANES-1:0]         lane_en,
  output logic                     start_div,
  output logic                     wb_valid,
  output logic [$clog2(VLMAX)-1:0] wb_eidx,
  output logic [LANES-1:0]         wb_lane_en,
  output logic                     busy,
  output logic                     done
);
  localparam int EW = $clog2(VLMAX);
  localparam int VW = EW + 1;

  typedef enum logic [2:0] {
    IDLE, ISSUE, DIV_WAIT, DRAIN, DONE
  } state_t;

  state_t           state;
  fu_t              fu_q;
  logic [VW-1:0]    vl_q;
  logic [VW-1:0]    vl_clamp;
  logic [EW-1:0]    eidx_q;
  logic             sticky;
  logic [MUL_LAT-1:0] pv;
  logic [EW-1:0]    pe [MUL_LAT];
  logic [LANES-1:0] pl [MUL_LAT];
  logic [LANES-1:0] beat_lanes;
  logic             last_beat;
  logic             issue;
  logic             is_mul;
  logic             is_div;
  logic             div_wb;
  logic             to_wb;
  logic             inflight;

  always_comb begin
    beat_lanes = '0;
    for (int i = 0; i < LANES; i++)
      beat_lanes[i] = (int'(eidx_q) + i) < int'(vl_q);
    inflight = 1'b0;
    for (int i = 0; i < MUL_LAT - 1; i++)
      inflight = inflight | pv[i];
  end

  assign last_beat = (int'(eidx_q) + LANES) >= int'(vl_q);
  assign vl_clamp  = (vl > VW'(VLMAX)) ? VW'(VLMAX) : vl;
  assign is_mul    = fu_q == MUL;
  assign is_div    = fu_q == DIV;
  assign issue     = (state == ISSUE) && !stall && !abort;
  assign div_wb    = (state == DIV_WAIT) && !stall && !abort
                     && (done_du || sticky);
  // Latency-1 units and divide results land directly in the last stage
  assign to_wb     = (issue && !is_mul && !is_div) || div_wb;

  assign fu_valid   = issue;
  assign start_div  = issue && is_div;
  assign eidx       = eidx_q;
  assign lane_en    = issue ? beat_lanes : '0;
  assign wb_valid   = pv[MUL_LAT-1];
  assign wb_eidx    = pe[MUL_LAT-1];
  assign wb_lane_en = pl[MUL_LAT-1];
  assign busy       = state != IDLE;
  assign done       = (state == DONE) && !stall && !abort;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      fu_q   <= ARITH;
      vl_q   <= '0;
      eidx_q <= '0;
      sticky <= 1'b0;
    end else if (abort) begin
      state  <= IDLE;
      sticky <= 1'b0;
    end else if (stall) begin
      if (state == DIV_WAIT && done_du)
        sticky <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            fu_q   <= fu_type;
            vl_q   <= vl_clamp;
            eidx_q <= '0;
            state  <= (vl_clamp == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (is_div)
            state <= DIV_WAIT;
          else if (last_beat)
            state <= DRAIN;
          else
            eidx_q <= eidx_q + EW'(LANES);
        end
        DIV_WAIT: begin
          if (done_du || sticky) begin
            sticky <= 1'b0;
            if (last_beat) begin
              state <= DRAIN;
            end else begin
              eidx_q <= eidx_q + EW'(LANES);
              state  <= ISSUE;
            end
          end
        end
        DRAIN: begin
          if (!inflight)
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pv <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        pe[i] <= '0;
        pl[i] <= '0;
      end
    end else if (abort) begin
      pv <= '0;
    end else if (!stall) begin
      pv[0] <= issue && is_mul;
      pe[0] <= eidx_q;
      pl[0] <= beat_lanes;
      for (int i = 1; i < MUL_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pl[i] <= pl[i-1];
      end
      if (to_wb) begin
        pv[MUL_LAT-1] <= 1'b1;
        pe[MUL_LAT-1] <= eidx_q;
        pl[MUL_LAT-1] <= beat_lanes;
      end
    end
  end
endmodule
